snoop_cache: RTL and testbench

- Two-way set-associative, write-through L1 cache with bus snooping. It sits between one CPU port (instruction or data side) and the shared system bus, alongside a bus arbiter and the memory slave.
- Misses, writes and uncached accesses become bus transactions after the arbiter grants the bus.
- Writes by other bus masters are snooped so that cached copies stay coherent (I-cache sees D-cache stores).

---
 rtl/snoop_cache_pkg.sv | 17 +
 rtl/cache_way_array.sv | 56 +++++
 rtl/snoop_cache.sv | 174 +++++++++++++++++
 tb/tb_snoop_cache.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/snoop_cache_pkg.sv
// Shared constants and FSM encoding for the snooping write-through L1 cache.
package snoop_cache_pkg;

   localparam int unsigned INDEX_BITS_DEF = 6;
   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned OFFSET_BITS    = 2;
   localparam int unsigned TAG_W_DEF      = ADDR_W_DEF - INDEX_BITS_DEF - OFFSET_BITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/cache_way_array.sv
// One cache way: tag/data storage with an asynchronously cleared valid vector.
// Has a CPU lookup port, a snoop lookup port and a single write port.
module cache_way_array
   import snoop_cache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
   parameter int unsigned TAG_W      = TAG_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic [TAG_W-1:0]      rd_tag,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   input  logic [INDEX_BITS-1:0] sn_index,
   output logic [TAG_W-1:0]      sn_tag,
   output logic                  sn_valid,
   input  logic                  we,
   input  logic                  fill,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_W-1:0]     wr_data
);

   localparam int unsigned SETS = 1 << INDEX_BITS;

   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [DATA_W-1:0] data_mem [SETS];
   logic [SETS-1:0]   valid;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         valid <= '0;
      end else if (we && fill) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Data-only writes (write hit, snoop) leave tag and valid untouched.
   always_ff @(posedge clk) begin
      if (we) begin
         data_mem[wr_index] <= wr_data;
      end
      if (we && fill) begin
         tag_mem[wr_index] <= wr_tag;
      end
   end

   assign rd_tag   = tag_mem[rd_index];
   assign rd_valid = valid[rd_index];
   assign rd_data  = data_mem[rd_index];
   assign sn_tag   = tag_mem[sn_index];
   assign sn_valid = valid[sn_index];

endmodule

// File: rtl/snoop_cache.sv
// Two-way set-associative write-through L1 cache with bus snooping.
// Misses, writes and uncached accesses run a REQ/XFER/DONE bus transaction.
module snoop_cache
   import snoop_cache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cpu_stall,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic              cpu_uncached,
   output logic [DATA_W-1:0] cpu_dout,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] cpu_addr_q,
   output logic [ADDR_W-1:0] bus_addr,
   inout  logic [DATA_W-1:0] bus_data,
   output logic              bus_req,
   inout  logic              bus_rw,
   input  logic              bus_grant,
   input  logic              bus_ready,
   output logic              hit_a,
   output logic              hit_b
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
   localparam int unsigned SETS  = 1 << INDEX_BITS;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q, fetch_q, dout_q;
   logic              req_q, rw_q, unc_q;
   logic [SETS-1:0]   lru;

   logic [INDEX_BITS-1:0] idx_q, sn_idx, wr_index;
   logic [TAG_W-1:0]      tag_q, sn_tag_in;
   logic [DATA_W-1:0]     wr_data;
   logic [TAG_W-1:0]      rd_tag [2];
   logic [TAG_W-1:0]      sn_tag [2];
   logic [DATA_W-1:0]     rd_data [2];
   logic [1:0]            rd_valid, sn_valid, hit, shit, we_w, fill_w;
   logic                  drive, own_done, snoop_fire, read_hit, fwd;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         addr_q <= '0;
         din_q  <= '0;
         req_q  <= 1'b0;
         rw_q   <= 1'b0;
         unc_q  <= 1'b0;
      end else if (!cpu_stall) begin
         addr_q <= cpu_addr;
         din_q  <= cpu_din;
         req_q  <= cpu_req;
         rw_q   <= cpu_rw;
         unc_q  <= cpu_uncached;
      end
   end

   assign idx_q      = addr_q[OFFSET_BITS +: INDEX_BITS];
   assign tag_q      = addr_q[ADDR_W-1 -: TAG_W];
   assign sn_idx     = bus_addr[OFFSET_BITS +: INDEX_BITS];
   assign sn_tag_in  = bus_addr[ADDR_W-1 -: TAG_W];
   assign drive      = (state == ST_XFER);
   assign own_done   = drive && bus_ready;
   assign snoop_fire = !bus_grant && bus_ready && bus_rw;
   assign wr_index   = own_done ? idx_q : sn_idx;
   assign wr_data    = (own_done && rw_q) ? din_q : bus_data;

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way_array #(
         .INDEX_BITS(INDEX_BITS),
         .TAG_W     (TAG_W),
         .DATA_W    (DATA_W)
      ) u_way (
         .clk      (clk),
         .clr      (clr),
         .rd_index (idx_q),
         .rd_tag   (rd_tag[w]),
         .rd_valid (rd_valid[w]),
         .rd_data  (rd_data[w]),
         .sn_index (sn_idx),
         .sn_tag   (sn_tag[w]),
         .sn_valid (sn_valid[w]),
         .we       (we_w[w]),
         .fill     (fill_w[w]),
         .wr_index (wr_index),
         .wr_tag   (tag_q),
         .wr_data  (wr_data)
      );
      assign hit[w]    = rd_valid[w] && (rd_tag[w] == tag_q);
      assign shit[w]   = sn_valid[w] && (sn_tag[w] == sn_tag_in);
      assign fill_w[w] = own_done && !rw_q && !unc_q &&
                         ((w == 1) ? lru[idx_q] : !lru[idx_q]);
      assign we_w[w]   = fill_w[w] ||
                         (own_done && rw_q && !unc_q && hit[w]) ||
                         (snoop_fire && shit[w]);
   end

   assign hit_a    = hit[0];
   assign hit_b    = hit[1];
   assign read_hit = (state == ST_IDLE) && req_q && !rw_q && !unc_q && (hit != 2'b00);
   // A same-cycle snoop of the line being read wins over the stale array copy.
   assign fwd      = snoop_fire && (sn_idx == idx_q) && ((hit & shit) != 2'b00);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         lru <= '0;
      end else if (own_done && !rw_q && !unc_q) begin
         lru[idx_q] <= ~lru[idx_q];
      end else if (read_hit) begin
         lru[idx_q] <= hit[0];
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= ST_IDLE;
         fetch_q <= '0;
         dout_q  <= '0;
      end else begin
         state  <= state_nxt;
         dout_q <= cpu_dout;
         if (own_done) begin
            fetch_q <= bus_data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      bus_req   = 1'b0;
      cpu_ready = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cpu_ready = !req_q || read_hit;
            if (req_q && !read_hit) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            bus_req = 1'b1;
            if (bus_grant) state_nxt = ST_XFER;
         end
         ST_XFER: begin
            bus_req = 1'b1;
            if (bus_ready) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            cpu_ready = 1'b1;
            if (!cpu_stall) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_dout = dout_q;
      if (read_hit) begin
         cpu_dout = fwd ? bus_data : (hit[0] ? rd_data[0] : rd_data[1]);
      end else if (state == ST_DONE && !rw_q) begin
         cpu_dout = fetch_q;
      end
   end

   assign cpu_addr_q = addr_q;
   assign bus_addr   = drive ? addr_q : 'z;
   assign bus_rw     = drive ? rw_q : 1'bz;
   assign bus_data   = (drive && rw_q) ? din_q : 'z;

endmodule

// File: tb/tb_snoop_cache.sv
// Directed bench for snoop_cache: plays CPU, arbiter, memory slave and a second bus master.
module tb_snoop_cache;

   logic        clk, clr, cpu_stall, tb_hold;
   logic [31:0] cpu_addr, cpu_din, cpu_dout, cpu_addr_q;
   logic        cpu_req, cpu_rw, cpu_uncached, cpu_ready;
   logic        bus_req, bus_grant, bus_ready, hit_a, hit_b;
   wire  [31:0] bus_addr, bus_data;
   wire         bus_rw;

   logic        mem_oe, oth_oe, oth_rw;
   logic [31:0] mem_data, oth_addr, oth_data;

   int checks   = 0;
   int failures = 0;

   assign bus_addr  = oth_oe ? oth_addr : 'z;
   assign bus_rw    = oth_oe ? oth_rw : 1'bz;
   assign bus_data  = mem_oe ? mem_data : (oth_oe ? oth_data : 'z);
   assign cpu_stall = ~cpu_ready | tb_hold;

   snoop_cache #(.INDEX_BITS(6), .ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .clr          (clr),
      .cpu_stall    (cpu_stall),
      .cpu_addr     (cpu_addr),
      .cpu_din      (cpu_din),
      .cpu_req      (cpu_req),
      .cpu_rw       (cpu_rw),
      .cpu_uncached (cpu_uncached),
      .cpu_dout     (cpu_dout),
      .cpu_ready    (cpu_ready),
      .cpu_addr_q   (cpu_addr_q),
      .bus_addr     (bus_addr),
      .bus_data     (bus_data),
      .bus_req      (bus_req),
      .bus_rw       (bus_rw),
      .bus_grant    (bus_grant),
      .bus_ready    (bus_ready),
      .hit_a        (hit_a),
      .hit_b        (hit_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request for one clock edge, then drop cpu_req.
   task automatic issue(input logic [31:0] a, input logic rw, input logic [31:0] d, input logic unc);
      cpu_addr     = a;
      cpu_rw       = rw;
      cpu_din      = d;
      cpu_uncached = unc;
      cpu_req      = 1'b1;
      @(negedge clk);
      cpu_req      = 1'b0;
   endtask

   // Grant and complete one DUT bus transaction, checking what it drives.
   task automatic serve(input string nm, input logic [31:0] a, input logic rw,
                        input logic [31:0] d, input logic hold);
      int n = 0;
      while (bus_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_bus_req"}, 32'(bus_req), 32'd1);
      bus_grant = 1'b1;
      @(negedge clk);
      chk({nm, "_bus_addr"}, bus_addr, a);
      chk({nm, "_bus_rw"}, 32'(bus_rw), 32'(rw));
      if (rw) chk({nm, "_bus_data"}, bus_data, d);
      chk({nm, "_ready_xfer"}, 32'(cpu_ready), 32'd0);
      if (!rw) begin
         mem_oe   = 1'b1;
         mem_data = d;
      end
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      bus_grant = 1'b0;
      mem_oe    = 1'b0;
      chk({nm, "_ready_done"}, 32'(cpu_ready), 32'd1);
      if (!rw) chk({nm, "_dout_done"}, cpu_dout, d);
      if (hold) begin
         tb_hold = 1'b1;
         @(negedge clk);
         chk({nm, "_ready_hold"}, 32'(cpu_ready), 32'd1);
         if (!rw) chk({nm, "_dout_hold"}, cpu_dout, d);
         tb_hold = 1'b0;
      end
      @(negedge clk);
      chk({nm, "_bus_req_idle"}, 32'(bus_req), 32'd0);
      chk({nm, "_ready_idle"}, 32'(cpu_ready), 32'd1);
   endtask

   initial begin
      clr = 1'b0; tb_hold = 1'b0;
      cpu_addr = '0; cpu_din = '0; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_uncached = 1'b0;
      bus_grant = 1'b0; bus_ready = 1'b0;
      mem_oe = 1'b0; mem_data = '0; oth_oe = 1'b0; oth_rw = 1'b0; oth_addr = '0; oth_data = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_addr_q", cpu_addr_q, 32'h0);
      chk("rst_ready", 32'(cpu_ready), 32'd1);
      chk("rst_hits", {30'd0, hit_a, hit_b}, 32'd0);
      chk("rst_dout", cpu_dout, 32'h0);
      clr = 1'b1;
      @(negedge clk);

      // Cold read miss fills way A of set 0.
      issue(32'h0000_0000, 1'b0, '0, 1'b0);
      chk("miss0_ready", 32'(cpu_ready), 32'd0);
      chk("miss0_hits", {30'd0, hit_a, hit_b}, 32'd0);
      serve("miss0", 32'h0000_0000, 1'b0, 32'h1111_0000, 1'b0);
      chk("miss0_dout_hold", cpu_dout, 32'h1111_0000);

      issue(32'h0000_0000, 1'b0, '0, 1'b0);
      chk("hit0_hit_a", 32'(hit_a), 32'd1);
      chk("hit0_ready", 32'(cpu_ready), 32'd1);
      chk("hit0_dout", cpu_dout, 32'h1111_0000);
      chk("hit0_bus_req", 32'(bus_req), 32'd0);
      @(negedge clk);
      chk("hit0_bus_req_next", 32'(bus_req), 32'd0);

      // Write-through hit, held in DONE for one extra cycle.
      issue(32'h0000_0000, 1'b1, 32'h0AB2_112B, 1'b0);
      chk("wr0_ready", 32'(cpu_ready), 32'd0);
      serve("wr0", 32'h0000_0000, 1'b1, 32'h0AB2_112B, 1'b1);
      issue(32'h0000_0000, 1'b0, '0, 1'b0);
      chk("wr0_rd_hit", 32'(hit_a), 32'd1);
      chk("wr0_rd_dout", cpu_dout, 32'h0AB2_112B);
      @(negedge clk);

      // Fill 0x04, then another master writes it.
      issue(32'h0000_0004, 1'b0, '0, 1'b0);
      serve("miss4", 32'h0000_0004, 1'b0, 32'h2222_0004, 1'b0);
      oth_oe = 1'b1; oth_addr = 32'h0000_0004; oth_data = 32'h0AB2_1123; oth_rw = 1'b1;
      bus_ready = 1'b1;
      @(negedge clk);
      oth_oe = 1'b0; bus_ready = 1'b0;
      issue(32'h0000_0004, 1'b0, '0, 1'b0);
      chk("snoop_hit", 32'(hit_a), 32'd1);
      chk("snoop_ready", 32'(cpu_ready), 32'd1);
      chk("snoop_dout", cpu_dout, 32'h0AB2_1123);
      chk("snoop_bus_req", 32'(bus_req), 32'd0);
      @(negedge clk);

      // Uncached read bypasses the cached copy and does not fill.
      issue(32'h0000_0004, 1'b0, '0, 1'b1);
      chk("unc_ready", 32'(cpu_ready), 32'd0);
      serve("unc4", 32'h0000_0004, 1'b0, 32'h7777_0004, 1'b0);
      issue(32'h0000_0004, 1'b0, '0, 1'b0);
      chk("unc_after_dout", cpu_dout, 32'h0AB2_1123);
      @(negedge clk);

      // Set-0 conflict: 0x100 takes way B, 0x200 evicts 0x000 from way A.
      issue(32'h0000_0000, 1'b0, '0, 1'b0);
      chk("set0_a_hit", 32'(hit_a), 32'd1);
      @(negedge clk);
      issue(32'h0000_0100, 1'b0, '0, 1'b0);
      chk("set0_100_miss", 32'(cpu_ready), 32'd0);
      serve("m100", 32'h0000_0100, 1'b0, 32'h3333_0100, 1'b0);
      issue(32'h0000_0200, 1'b0, '0, 1'b0);
      chk("set0_200_miss", 32'(cpu_ready), 32'd0);
      serve("m200", 32'h0000_0200, 1'b0, 32'h4444_0200, 1'b0);
      issue(32'h0000_0100, 1'b0, '0, 1'b0);
      chk("set0_100_hit_b", 32'(hit_b), 32'd1);
      chk("set0_100_dout", cpu_dout, 32'h3333_0100);
      @(negedge clk);
      issue(32'h0000_0000, 1'b0, '0, 1'b0);
      chk("set0_000_evicted", 32'(cpu_ready), 32'd0);
      serve("m000", 32'h0000_0000, 1'b0, 32'h5555_0000, 1'b0);

      // Reset in the middle of a transfer.
      issue(32'h0000_0008, 1'b0, '0, 1'b0);
      for (int i = 0; i < 20 && bus_req !== 1'b1; i++) @(negedge clk);
      bus_grant = 1'b1;
      @(negedge clk);
      chk("clr_pre_addr", bus_addr, 32'h0000_0008);
      clr = 1'b0;
      bus_grant = 1'b0;
      #1;
      chk("clr_bus_req", 32'(bus_req), 32'd0);
      chk("clr_addr_q", cpu_addr_q, 32'h0);
      oth_oe = 1'b1; oth_addr = 32'h0; oth_rw = 1'b0; oth_data = 32'h0;
      #1;
      chk("clr_bus_addr_released", bus_addr, 32'h0);
      chk("clr_bus_rw_released", 32'(bus_rw), 32'd0);
      oth_oe = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      issue(32'h0000_0004, 1'b0, '0, 1'b0);
      chk("clr_inval_ready", 32'(cpu_ready), 32'd0);
      chk("clr_inval_hits", {30'd0, hit_a, hit_b}, 32'd0);
      serve("post_clr", 32'h0000_0004, 1'b0, 32'h6666_0004, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
